// File: rtl/encoder_emulator_pkg.sv
// ----------------------------------------------------------------------------
// encoder_emulator_pkg
//   Shared definitions for the quadrature encoder emulator:
//   - state_t      : step sequencer states (IDLE, PH1, PH2, PH3, GAP)
//   - dir_t        : latched step direction codes (DIR_INC, DIR_DEC)
//   - phase_levels : {A,B} output levels for a given state and direction
//   No ports (package only).
// ----------------------------------------------------------------------------
package encoder_emulator_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_t;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

  // {A,B} levels. Clockwise: A leads (A falls first); counter-clockwise: B leads.
  // Consecutive entries differ in exactly one bit (Gray order).
  function automatic logic [1:0] phase_levels(input state_t s, input dir_t d);
    logic [1:0] lv;
    lv = 2'b11;
    case (s)
      PH1:     lv = (d == DIR_INC) ? 2'b01 : 2'b10;
      PH2:     lv = 2'b00;
      PH3:     lv = (d == DIR_INC) ? 2'b10 : 2'b01;
      default: lv = 2'b11;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/encoder_emulator_phase_timer.sv
// ----------------------------------------------------------------------------
// encoder_emulator_phase_timer
//   Loadable down-counter that times one sequencer state.
//   Loading value N produces an expire pulse N+1 clocks later (the caller loads
//   duration-1), so a state entered on the load edge lasts exactly duration clocks.
// Ports:
//   Clock  in  1      system clock
//   Reset  in  1      asynchronous active-low reset
//   load   in  1      restart the count with value
//   value  in  WIDTH  count to load
//   expire out 1      one-clock pulse when the loaded count has run out
// ----------------------------------------------------------------------------
module encoder_emulator_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] count_reg;
  logic             active_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (load) begin
      count_reg  <= value;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (count_reg == '0) active_reg <= 1'b0;
      else                 count_reg  <= count_reg - 1'b1;
    end
  end

  // Gated by active so an idle, drained counter does not keep firing.
  assign expire = active_reg && (count_reg == '0);

endmodule

// File: rtl/encoder_emulator.sv
// ----------------------------------------------------------------------------
// encoder_emulator
//   Quadrature output generator: converts one-clock Increment/Decrement requests
//   into A/B waveforms of a mechanical detent encoder (idle high, active low).
//   Requests are queued as a saturating signed pending count; one full detent
//   (4 Gray-ordered edges followed by a high gap) is emitted per step.
// Parameters:
//   PHASE_CLOCKS  clocks between successive A/B edges
//   GAP_CLOCKS    clocks A=B=1 held after the 4th edge
//   PENDING_MAX   saturation magnitude of the queued step count
// Ports:
//   Clock        in  1  system clock
//   Reset        in  1  asynchronous active-low reset
//   Increment_i  in  1  one-clock request: queue one clockwise step
//   Decrement_i  in  1  one-clock request: queue one counter-clockwise step
//   A_o          out 1  quadrature channel A (registered)
//   B_o          out 1  quadrature channel B (registered)
//   Busy_o       out 1  step in progress or steps pending (registered)
//   Overflow_o   out 1  one-clock pulse when a request is dropped at saturation
//   Done_o       out 1  only with ENCODER_EMULATOR_DONE_EN defined: one-clock
//                       pulse on the GAP->IDLE transition of each completed step
// ----------------------------------------------------------------------------
module encoder_emulator
  import encoder_emulator_pkg::*;
#(
  parameter int PHASE_CLOCKS = 5000,
  parameter int GAP_CLOCKS   = 15000,
  parameter int PENDING_MAX  = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Increment_i,
  input  logic Decrement_i,
  output logic A_o,
  output logic B_o,
  output logic Busy_o,
  output logic Overflow_o
`ifdef ENCODER_EMULATOR_DONE_EN
  ,
  output logic Done_o
`endif
);

  localparam int PW     = $clog2(PENDING_MAX + 1) + 1;
  localparam int MAXDUR = (PHASE_CLOCKS > GAP_CLOCKS) ? PHASE_CLOCKS : GAP_CLOCKS;
  localparam int TW     = $clog2(MAXDUR + 1);

  localparam logic signed [PW-1:0] PEND_MAX = PW'(PENDING_MAX);
  localparam logic signed [PW-1:0] PEND_MIN = -PW'(PENDING_MAX);
  localparam logic signed [PW-1:0] PEND_ONE = PW'(1);

  state_t                 state_reg, state_next;
  dir_t                   dir_reg, dir_next;
  logic signed [PW-1:0]   pending_reg, pending_next, pending_base;
  logic                   dequeue, req_up, req_dn, drop;
  logic                   load;
  logic [TW-1:0]          load_value;
  logic                   expire;
  logic [1:0]             levels;
  logic                   a_reg, b_reg, busy_reg, overflow_reg;

  encoder_emulator_phase_timer #(.WIDTH(TW)) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .load   (load),
    .value  (load_value),
    .expire (expire)
  );

  always_comb begin
    dequeue      = (state_reg == IDLE) && (pending_reg != '0);
    dir_next     = dir_reg;
    pending_base = pending_reg;
    // Starting a step moves the queue one toward zero before this edge's request lands.
    if (dequeue) begin
      dir_next     = pending_reg[PW-1] ? DIR_DEC : DIR_INC;
      pending_base = pending_reg[PW-1] ? pending_reg + PEND_ONE : pending_reg - PEND_ONE;
    end

    // Simultaneous Increment and Decrement cancel out.
    req_up = Increment_i && !Decrement_i;
    req_dn = Decrement_i && !Increment_i;
    drop   = (req_up && pending_base == PEND_MAX) || (req_dn && pending_base == PEND_MIN);

    pending_next = pending_base;
    if (req_up && !drop)      pending_next = pending_base + PEND_ONE;
    else if (req_dn && !drop) pending_next = pending_base - PEND_ONE;

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (dequeue) state_next = PH1;
      PH1:     if (expire)  state_next = PH2;
      PH2:     if (expire)  state_next = PH3;
      PH3:     if (expire)  state_next = GAP;
      GAP:     if (expire)  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Timer restarts on every state entry; its expiry in IDLE is simply ignored.
    load = (state_next != state_reg);
    case (state_next)
      GAP:     load_value = TW'(GAP_CLOCKS - 1);
      IDLE:    load_value = '0;
      default: load_value = TW'(PHASE_CLOCKS - 1);
    endcase

    levels = phase_levels(state_next, dir_next);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= IDLE;
      dir_reg      <= DIR_INC;
      pending_reg  <= '0;
      a_reg        <= 1'b1;
      b_reg        <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dir_reg      <= dir_next;
      pending_reg  <= pending_next;
      a_reg        <= levels[1];
      b_reg        <= levels[0];
      busy_reg     <= (state_next != IDLE) || (pending_next != '0);
      overflow_reg <= drop;
    end
  end

  assign A_o        = a_reg;
  assign B_o        = b_reg;
  assign Busy_o     = busy_reg;
  assign Overflow_o = overflow_reg;

`ifdef ENCODER_EMULATOR_DONE_EN
  logic done_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) done_reg <= 1'b0;
    else        done_reg <= (state_reg == GAP) && expire;
  end

  assign Done_o = done_reg;
`endif

endmodule

// File: tb/tb_encoder_emulator.sv
// ----------------------------------------------------------------------------
// tb_encoder_emulator
//   Directed bench for encoder_emulator with PHASE_CLOCKS=4, GAP_CLOCKS=8,
//   PENDING_MAX=3. A small quadrature decoder model counts detents and edges.
// ----------------------------------------------------------------------------
module tb_encoder_emulator;

  localparam int P = 4;
  localparam int G = 8;
  localparam int M = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Increment_i = 1'b0;
  logic Decrement_i = 1'b0;
  logic A_o, B_o, Busy_o, Overflow_o;
`ifdef ENCODER_EMULATOR_DONE_EN
  logic Done_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;
  int incs     = 0;
  int decs     = 0;
  int gray_err = 0;
  int dones    = 0;
  logic [1:0] prev_ab = 2'b11;

  int base_edges, base_incs, base_decs;

  encoder_emulator #(
    .PHASE_CLOCKS (P),
    .GAP_CLOCKS   (G),
    .PENDING_MAX  (M)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Increment_i (Increment_i),
    .Decrement_i (Decrement_i),
    .A_o         (A_o),
    .B_o         (B_o),
    .Busy_o      (Busy_o),
    .Overflow_o  (Overflow_o)
`ifdef ENCODER_EMULATOR_DONE_EN
    ,
    .Done_o      (Done_o)
`endif
  );

  always #5 Clock = ~Clock;

  // Decoder model: a detent completes on return to 11; from 10 it was clockwise
  // (11->01->00->10->11), from 01 counter-clockwise.
  always @(negedge Clock) begin
    if (!Reset) begin
      prev_ab = {A_o, B_o};
    end else if ({A_o, B_o} != prev_ab) begin
      edges++;
      if (({A_o, B_o} ^ prev_ab) == 2'b11) gray_err++;
      if ({A_o, B_o} == 2'b11) begin
        if (prev_ab == 2'b10)      incs++;
        else if (prev_ab == 2'b01) decs++;
      end
      prev_ab = {A_o, B_o};
    end
`ifdef ENCODER_EMULATOR_DONE_EN
    if (Done_o) dones++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Hold for n clocks expecting {A,B}=lv and Busy_o=1 after each edge.
  task automatic expect_phase(input string tag, input logic [1:0] lv, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {29'd0, A_o, B_o, Busy_o}, {29'd0, lv, 1'b1});
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (!Busy_o) break;
      tick();
    end
    chk(tag, {31'd0, Busy_o}, 32'd0);
  endtask

  task automatic mark();
    base_edges = edges;
    base_incs  = incs;
    base_decs  = decs;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("reset_state", {28'd0, A_o, B_o, Busy_o, Overflow_o}, 32'b1100);
    Reset = 1'b1;

    // Test 1: idle after release
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("t1_idle", {29'd0, A_o, B_o, Busy_o}, 32'b110);
    end

    // Test 2: single increment, full waveform with timing
    mark();
    Increment_i = 1'b1;
    tick();
    Increment_i = 1'b0;
    chk("t2_queued", {29'd0, A_o, B_o, Busy_o}, 32'b111);
    expect_phase("t2_ph1", 2'b01, P);
    expect_phase("t2_ph2", 2'b00, P);
    expect_phase("t2_ph3", 2'b10, P);
    expect_phase("t2_gap", 2'b11, G);
    tick();
    chk("t2_idle", {29'd0, A_o, B_o, Busy_o}, 32'b110);
    tick();
    chk("t2_incs", incs - base_incs, 32'd1);
    chk("t2_decs", decs - base_decs, 32'd0);
    chk("t2_edges", edges - base_edges, 32'd4);

    // Test 3: single decrement, B leads
    mark();
    Decrement_i = 1'b1;
    tick();
    Decrement_i = 1'b0;
    chk("t3_queued", {29'd0, A_o, B_o, Busy_o}, 32'b111);
    expect_phase("t3_ph1", 2'b10, P);
    expect_phase("t3_ph2", 2'b00, P);
    expect_phase("t3_ph3", 2'b01, P);
    expect_phase("t3_gap", 2'b11, G);
    tick();
    chk("t3_idle", {29'd0, A_o, B_o, Busy_o}, 32'b110);
    tick();
    chk("t3_decs", decs - base_decs, 32'd1);
    chk("t3_incs", incs - base_incs, 32'd0);
    chk("t3_edges", edges - base_edges, 32'd4);

    // Test 4: five increments back-to-back, fifth overflows
    mark();
    for (int i = 0; i < 5; i++) begin
      Increment_i = 1'b1;
      tick();
      chk("t4_ovf", {31'd0, Overflow_o}, (i == 4) ? 32'd1 : 32'd0);
    end
    Increment_i = 1'b0;
    tick();
    chk("t4_ovf_clear", {31'd0, Overflow_o}, 32'd0);
    wait_idle("t4_idle_timeout");
    tick();
    chk("t4_incs", incs - base_incs, 32'd4);
    chk("t4_edges", edges - base_edges, 32'd16);

    // Test 4b: negative saturation
    mark();
    for (int i = 0; i < 5; i++) begin
      Decrement_i = 1'b1;
      tick();
      chk("t4b_ovf", {31'd0, Overflow_o}, (i == 4) ? 32'd1 : 32'd0);
    end
    Decrement_i = 1'b0;
    wait_idle("t4b_idle_timeout");
    tick();
    chk("t4b_decs", decs - base_decs, 32'd4);
    chk("t4b_incs", incs - base_incs, 32'd0);

    // Test 5: simultaneous Inc+Dec while idle does nothing
    mark();
    Increment_i = 1'b1;
    Decrement_i = 1'b1;
    tick();
    Increment_i = 1'b0;
    Decrement_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_noop", {28'd0, A_o, B_o, Busy_o, Overflow_o}, 32'b1100);
      tick();
    end
    chk("t5_noop_edges", edges - base_edges, 32'd0);

    // Test 5b: Inc starts a step; Inc then Dec during it cancel out
    mark();
    Increment_i = 1'b1;
    tick();
    Increment_i = 1'b0;
    tick();
    chk("t5b_ph1", {29'd0, A_o, B_o, Busy_o}, 32'b011);
    Increment_i = 1'b1;
    tick();
    Increment_i = 1'b0;
    Decrement_i = 1'b1;
    tick();
    Decrement_i = 1'b0;
    chk("t5b_busy", {31'd0, Busy_o}, 32'd1);
    wait_idle("t5b_idle_timeout");
    tick();
    chk("t5b_incs", incs - base_incs, 32'd1);
    chk("t5b_decs", decs - base_decs, 32'd0);
    chk("t5b_edges", edges - base_edges, 32'd4);

    chk("gray_order", gray_err, 32'd0);
`ifdef ENCODER_EMULATOR_DONE_EN
    chk("done_pulses", dones, 32'd11);
`endif

    // Test 6: reset in PH2 with two steps pending
    Increment_i = 1'b1;
    repeat (3) tick();
    Increment_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ({A_o, B_o} == 2'b00) break;
      tick();
    end
    chk("t6_reach_ph2", {29'd0, A_o, B_o, Busy_o}, 32'b001);
    Reset = 1'b0;
    #1;
    chk("t6_async_reset", {28'd0, A_o, B_o, Busy_o, Overflow_o}, 32'b1100);
    tick();
    tick();
    Reset = 1'b1;
    mark();
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("t6_after_release", {29'd0, A_o, B_o, Busy_o}, 32'b110);
    end
    chk("t6_edges", edges - base_edges, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
